// File: rtl/imem_responder.sv
// imem_responder: instruction-memory side of the fetch interface.
// Fetch reads are combinational (zero latency). A byte-stream loader assembles
// little-endian 32-bit words and writes them into storage; while a load is in
// progress fetch sees NOP_WORD and ld_busy holds the core off.
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per stored word.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no load in progress; first accepted byte starts a new image
// S_ASSEMBLE | collecting bytes of the current word into lanes 0..3
// S_WRITE    | one cycle: commit assembled word (or flag overflow), bump wptr
// S_DONE     | one cycle: ld_done pulse, rewind wptr for the next load

module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_read,
    output logic [31:0] imem_data,
    output logic        imem_fault,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_overflow,
    output logic        parity_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_WRITE    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [31:0] word, word_nxt;
    logic [AW:0] wptr, wptr_nxt;
    logic        last_seen, last_seen_nxt;
    logic        overflow, overflow_nxt;
    logic        accept;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign ld_ready    = (state == S_IDLE) || (state == S_ASSEMBLE);
    assign ld_busy     = (state != S_IDLE);
    assign ld_done     = (state == S_DONE);
    assign ld_overflow = overflow;
    assign accept      = ld_valid & ld_ready;

    // Loader state and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            wptr      <= '0;
            last_seen <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_idx  <= byte_idx_nxt;
            word      <= word_nxt;
            wptr      <= wptr_nxt;
            last_seen <= last_seen_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // Loader next-state and datapath updates.
    always_comb begin
        state_nxt     = state;
        byte_idx_nxt  = byte_idx;
        word_nxt      = word;
        wptr_nxt      = wptr;
        last_seen_nxt = last_seen;
        overflow_nxt  = overflow;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    word_nxt      = {24'd0, ld_byte};
                    byte_idx_nxt  = 2'd1;
                    wptr_nxt      = '0;
                    overflow_nxt  = 1'b0;
                    last_seen_nxt = ld_last;
                    state_nxt     = ld_last ? S_WRITE : S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                if (accept) begin
                    word_nxt[{byte_idx, 3'b000} +: 8] = ld_byte;
                    byte_idx_nxt  = byte_idx + 2'd1;
                    last_seen_nxt = ld_last;
                    if ((byte_idx == 2'd3) || ld_last) begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // wptr saturates at DEPTH_WORDS so further words keep flagging overflow
                if (wptr[AW]) begin
                    overflow_nxt = 1'b1;
                end else begin
                    wptr_nxt = wptr + (AW+1)'(1);
                end
                byte_idx_nxt = 2'd0;
                word_nxt     = 32'd0;
                state_nxt    = last_seen ? S_DONE : S_ASSEMBLE;
            end
            S_DONE: begin
                wptr_nxt      = '0;
                last_seen_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset aborts a load without committing the word in flight.
    assign mem_we = (state == S_WRITE) && !wptr[AW] && !reset;

    // Word storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr[AW-1:0]] <= word;
        end
    end

    logic [AW-1:0] word_idx;
    logic          aligned;
    logic          in_range;
    logic          fetch_ok;
    logic [31:0]   rd_word;

    assign word_idx   = imem_addr[AW+1:2];
    assign aligned    = (imem_addr[1:0] == 2'b00);
    assign in_range   = (imem_addr[31:AW+2] == '0);
    assign fetch_ok   = imem_read & ~ld_busy & aligned & in_range;
    assign imem_fault = imem_read & ~ld_busy & (~aligned | ~in_range);
    assign rd_word    = mem[word_idx];

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH_WORDS];
    logic par_bad;

    // Even-parity bit stored alongside each word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_par[wptr[AW-1:0]] <= ^word;
        end
    end

    assign par_bad    = ^{rd_word, mem_par[word_idx]};
    assign parity_err = fetch_ok & par_bad;
    assign imem_data  = (fetch_ok & ~par_bad) ? rd_word : NOP_WORD;
`else
    assign parity_err = 1'b0;
    assign imem_data  = fetch_ok ? rd_word : NOP_WORD;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: randomized loader pacing and fetch
// traffic, compared against a byte-image model of storage.

module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_data;
    logic        imem_fault;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_overflow;
    logic        parity_err;

    imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_read(imem_read),
        .imem_data(imem_data), .imem_fault(imem_fault),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_overflow(ld_overflow), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_ovf;
    logic [7:0]  img [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_fault(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= DEPTH * 4);
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] addr);
        if (ref_fault(addr)) return NOP;
        return model_mem[addr / 4];
    endfunction

    // Little-endian word w of the current image; missing bytes read as zero.
    function automatic logic [31:0] img_word(input int w);
        logic [31:0] r = 32'd0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < img.size()) r = r | (32'(img[4 * w + b]) << (8 * b));
        return r;
    endfunction

    task automatic fetch_check(input logic [31:0] addr, input string tag);
        @(negedge clk);
        imem_addr = addr;
        imem_read = 1'b1;
        #1;
        check({tag, "_data"}, imem_data, ref_data(addr));
        check({tag, "_fault"}, 32'(imem_fault), 32'(ref_fault(addr)));
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
    endtask

    // Stream img into the loader with random gaps; abort_after>0 stops after
    // that many accepted bytes without ld_last and without waiting for done.
    task automatic load_image(input int abort_after);
        int  n       = img.size();
        int  idx     = 0;
        int  cyc     = 0;
        int  dk      = -1;
        int  dcnt    = 0;
        int  nwords;
        int  stop_at = (abort_after > 0) ? abort_after : n;
        bit  started = 0;
        bit  acc     = 0;
        ld_valid = 1'b0;
        while (idx < stop_at && cyc < 20 * n + 50) begin
            @(negedge clk);
            cyc++;
            if (started) begin
                imem_addr = $urandom_range(0, DEPTH * 4 - 1);
                imem_read = 1'($urandom_range(0, 1));
                #1;
                check("busy_during_load", 32'(ld_busy), 32'd1);
                check("nop_during_load", imem_data, NOP);
                check("nofault_during_load", 32'(imem_fault), 32'd0);
            end else begin
                imem_read = 1'b0;
            end
            if (acc || !ld_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    ld_valid = 1'b1;
                    ld_byte  = img[idx];
                    ld_last  = (abort_after == 0) && (idx == n - 1);
                end else begin
                    ld_valid = 1'b0;
                end
            end
            acc = ld_valid && ld_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                started = 1;
            end
        end
        if (idx != stop_at) check("load_timeout", 32'(idx), 32'(stop_at));
        nwords = (abort_after > 0) ? abort_after / 4 : (n + 3) / 4;
        if (abort_after == 0) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                ld_valid  = 1'b0;
                ld_last   = 1'b0;
                imem_addr = $urandom_range(0, 15) * 4;
                imem_read = 1'b1;
                #1;
                if (ld_done) begin
                    dcnt++;
                    if (dk < 0) dk = k;
                    check("busy_in_done", 32'(ld_busy), 32'd1);
                    check("nop_in_done", imem_data, NOP);
                end else if (dk >= 0 && k == dk + 1) begin
                    check("busy_after_done", 32'(ld_busy), 32'd0);
                end
            end
            check("done_pulses", 32'(dcnt), 32'd1);
        end
        for (int w = 0; w < nwords && w < DEPTH; w++) model_mem[w] = img_word(w);
        if (abort_after == 0) begin
            model_ovf = (nwords > DEPTH);
            check("overflow", 32'(ld_overflow), 32'(model_ovf));
        end
    endtask

    initial begin
        reset     = 1'b1;
        imem_addr = 32'd0;
        imem_read = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = 8'd0;
        ld_last   = 1'b0;
        model_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd1);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_ovf", 32'(ld_overflow), 32'd0);
        check("rst_data_noread", imem_data, NOP);
        check("rst_fault_noread", 32'(imem_fault), 32'd0);
        reset = 1'b0;

        // Two-word program
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_image(0);
        fetch_check(32'd0, "t1_w0");
        fetch_check(32'd4, "t1_w1");
        check("t1_w1_const", model_mem[1], 32'h00100093);

        // Partial word with ld_last
        img = '{8'hAA, 8'hBB};
        load_image(0);
        fetch_check(32'd0, "t2_w0");
        check("t2_w0_const", model_mem[0], 32'h0000BBAA);
        fetch_check(32'd4, "t2_w1_kept");

        // Faults and idle fetch
        fetch_check(32'd2, "t3_misaligned");
        fetch_check(DEPTH * 4, "t3_range");
        fetch_check(32'hFFFF_FFFC, "t3_high");
        @(negedge clk);
        imem_addr = 32'd4;
        imem_read = 1'b0;
        #1;
        check("t3_noread_data", imem_data, NOP);
        check("t3_noread_fault", 32'(imem_fault), 32'd0);

        // Random image, odd length, fetch traffic during load
        img = {};
        for (int i = 0; i < 43; i++) img.push_back(8'($urandom));
        load_image(0);
        for (int w = 0; w < 11; w++) fetch_check(32'(w * 4), "t4_word");

        // Overflow image: DEPTH+1 words
        img = {};
        for (int i = 0; i < 4 * (DEPTH + 1); i++) img.push_back(8'($urandom));
        load_image(0);
        for (int w = 0; w < DEPTH; w++) fetch_check(32'(w * 4), "t5_word");
        check("t5_ovf_sticky", 32'(ld_overflow), 32'd1);

        // Abort a new load with reset after 5 bytes
        img = {};
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        load_image(5);
        @(negedge clk);
        ld_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("t5_abort_busy", 32'(ld_busy), 32'd0);
        check("t5_abort_ovf", 32'(ld_overflow), 32'd0);
        check("t5_abort_ready", 32'(ld_ready), 32'd1);
        reset = 1'b0;
        fetch_check(32'd0, "t5_abort_w0");
        fetch_check(32'd4, "t5_abort_w1_kept");

        // Reload starts at word 0
        img = {};
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        load_image(0);
        for (int w = 0; w < 5; w++) fetch_check(32'(w * 4), "t5_reload");
        fetch_check(32'((DEPTH - 1) * 4), "t5_last_word");

`ifdef IMEM_PARITY_EN
        @(negedge clk);
        dut.mem[1] = dut.mem[1] ^ 32'h0000_0100;
        imem_addr = 32'd4;
        imem_read = 1'b1;
        #1;
        check("t6_perr", 32'(parity_err), 32'd1);
        check("t6_perr_data", imem_data, NOP);
        fetch_check(32'd0, "t6_good_word");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
